// File: rtl/pipe_alu.sv
// pipe_alu: registered ALU with valid/ready handshakes on both sides.
// Holds one result at a time. Single-cycle ops complete at the accept edge.
// MUL is a shift-add over WIDTH cycles.
//
// Handshake: an operation is accepted when valid_i && ready_o at a rising
// edge, and a result is consumed when valid_o && ready_i at a rising edge.
// ready_o depends combinationally on ready_i, so a held result can be consumed
// and replaced at the same edge.
//
// Ports:
//   clk, reset         clock (rising edge), async active-high reset
//   a_i, b_i, op_i     operands and opcode, sampled at accept only
//   valid_i / ready_o  operation handshake
//   alu_o, zero_o,     registered result and flags
//   carry_o
//   valid_o / ready_i  result handshake
//   dbg_state          current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module pipe_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] alu_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [1:0]       dbg_state
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand, acc, acc_add;
    logic [WIDTH-1:0]   mplier;
    logic [SHW:0]       cnt;

    logic               accept, consume, is_mul, mul_last;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_cy;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [SHW-1:0]     sh;

    assign accept    = valid_i && ready_o;
    assign consume   = valid_o && ready_i;
    assign is_mul    = (op_i == 4'b1011);
    assign mul_last  = (state == BUSY) && (cnt == CNT_LAST);
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. Accept in DONE implies consume, since ready_o in DONE
    // requires ready_i.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul ? BUSY : DONE;
            BUSY: if (mul_last) state_nxt = DONE;
            DONE: begin
                if (accept)       state_nxt = is_mul ? BUSY : DONE;
                else if (consume) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_o = (state == IDLE) || ((state == DONE) && ready_i);
        valid_o = (state == DONE);
    end

    // Single-cycle datapath. Rotates shift a doubled copy of a, so an amount
    // of 0 needs no special case.
    always_comb begin
        sh     = b_i[SHW-1:0];
        sum    = {1'b0, a_i} + {1'b0, b_i};
        diff   = {1'b0, a_i} - {1'b0, b_i};
        rot_l  = {a_i, a_i} << sh;
        rot_r  = {a_i, a_i} >> sh;
        sc_res = '0;
        sc_cy  = 1'b0;
        case (op_i)
            4'b0000: begin sc_res = sum[WIDTH-1:0];  sc_cy = sum[WIDTH];  end
            4'b0001: begin sc_res = diff[WIDTH-1:0]; sc_cy = diff[WIDTH]; end
            4'b0010: sc_res = a_i << sh;
            4'b0011: sc_res = a_i >> sh;
            4'b0100: sc_res = a_i & b_i;
            4'b0101: sc_res = a_i | b_i;
            4'b0110: sc_res = a_i ^ b_i;
            4'b0111: sc_res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            4'b1000: sc_res = rot_l[2*WIDTH-1:WIDTH];
            4'b1001: sc_res = rot_r[WIDTH-1:0];
            4'b1010: sc_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: begin sc_res = '0; sc_cy = 1'b0; end
        endcase
    end

    // One multiplier bit per cycle, LSB first
    assign acc_add = mplier[0] ? (acc + mcand) : acc;

    // Datapath registers. Accept never happens in BUSY, so the two branches
    // are exclusive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_o   <= '0;
            zero_o  <= 1'b1;
            carry_o <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, a_i};
                mplier <= b_i;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                alu_o   <= sc_res;
                zero_o  <= (sc_res == '0);
                carry_o <= sc_cy;
            end
        end else if (state == BUSY) begin
            acc    <= acc_add;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + (SHW+1)'(1);
            if (mul_last) begin
                alu_o   <= acc_add[WIDTH-1:0];
                zero_o  <= (acc_add[WIDTH-1:0] == '0);
                carry_o <= |acc_add[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_pipe_alu.sv
// Directed and streaming checks of pipe_alu at WIDTH=8 and WIDTH=16.
// Inputs are driven at the falling edge and outputs are sampled at the falling edge.
module tb_pipe_alu;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // WIDTH=8 instance
    logic [7:0]  a8 = '0, b8 = '0, alu8;
    logic [3:0]  op8 = '0;
    logic        v_i8 = 1'b0, r_i8 = 1'b0, r_o8, z8, c8, v_o8;
    logic [1:0]  st8;

    // WIDTH=16 instance
    logic [15:0] a16 = '0, b16 = '0, alu16;
    logic [3:0]  op16 = '0;
    logic        v_i16 = 1'b0, r_i16 = 1'b0, r_o16, z16, c16, v_o16;
    logic [1:0]  st16;

    logic [16:0] exp_q[$];

    pipe_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .a_i(a8), .b_i(b8), .op_i(op8),
        .valid_i(v_i8), .ready_o(r_o8), .alu_o(alu8), .zero_o(z8),
        .carry_o(c8), .valid_o(v_o8), .ready_i(r_i8), .dbg_state(st8)
    );

    pipe_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .a_i(a16), .b_i(b16), .op_i(op16),
        .valid_i(v_i16), .ready_o(r_o16), .alu_o(alu16), .zero_o(z16),
        .carry_o(c16), .valid_o(v_o16), .ready_i(r_i16), .dbg_state(st16)
    );

    // ---------------- reference model ----------------
    // Returns {carry, result}; result is zero-extended to 16 bits.
    function automatic logic [16:0] model(input int w, input logic [15:0] a_in,
                                          input logic [15:0] b_in, input logic [3:0] op);
        logic [31:0] mask, a, b, r, p;
        logic        c;
        int          sh;
        mask = (32'd1 << w) - 32'd1;
        a = {16'd0, a_in} & mask;
        b = {16'd0, b_in} & mask;
        sh = int'(b) % w;
        r = '0;
        c = 1'b0;
        case (op)
            4'd0:  begin p = a + b; r = p; c = p[w]; end
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  r = a << sh;
            4'd3:  r = a >> sh;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = {31'd0, (a == b)};
            4'd8:  begin
                for (int k = 0; k < sh; k++) a = ((a << 1) | (a >> (w - 1))) & mask;
                r = a;
            end
            4'd9:  begin
                for (int k = 0; k < sh; k++) a = (a >> 1) | ((a & 32'd1) << (w - 1));
                r = a;
            end
            4'd10: r = {31'd0, (a < b)};
            4'd11: begin p = a * b; r = p; c = ((p >> w) != 32'd0); end
            default: r = '0;
        endcase
        r = r & mask;
        return {c, r[15:0]};
    endfunction

    // ---------------- driver ----------------
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        @(negedge clk);
        a8 = a; b8 = b; op8 = op; v_i8 = 1'b1;
        @(posedge clk);
        #1 v_i8 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b0, 1'b0, 1'b1, 8'h00} || st8 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outs8: got v=%b c=%b z=%b alu=%h st=%0d, want v=0 c=0 z=1 alu=00 st=0",
                     v_o8, c8, z8, alu8, st8);
        end
        n_cmp++;
        if ({v_o16, c16, z16, alu16} !== {1'b0, 1'b0, 1'b1, 16'h0000} || st16 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outs16: got v=%b c=%b z=%b alu=%h, want v=0 c=0 z=1 alu=0000",
                     v_o16, c16, z16, alu16);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (r_o8 !== 1'b1 || r_o16 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got r8=%b r16=%b, want 1 1", r_o8, r_o16);
        end
    endtask

    task automatic test_add_sub();
        r_i8 = 1'b1;
        issue8(8'hF0, 8'h20, 4'b0000);
        @(negedge clk);
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b1, 1'b1, 1'b0, 8'h10}) begin
            n_fail++;
            $display("FAIL add: got v=%b c=%b z=%b alu=%h, want v=1 c=1 z=0 alu=10", v_o8, c8, z8, alu8);
        end
        issue8(8'h05, 8'h07, 4'b0001);
        @(negedge clk);
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b1, 1'b1, 1'b0, 8'hFE}) begin
            n_fail++;
            $display("FAIL sub: got v=%b c=%b z=%b alu=%h, want v=1 c=1 z=0 alu=fe", v_o8, c8, z8, alu8);
        end
    endtask

    task automatic test_mul();
        r_i8 = 1'b1;
        issue8(8'd13, 8'd11, 4'b1011);
        a8 = 8'hFF; b8 = 8'hFF;  // late operand changes must not matter
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (r_o8 !== 1'b0 || v_o8 !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_busy[%0d]: got ready=%b valid=%b, want 0 0", i, r_o8, v_o8);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b1, 1'b0, 1'b0, 8'h8F}) begin
            n_fail++;
            $display("FAIL mul_13x11: got v=%b c=%b z=%b alu=%h, want v=1 c=0 z=0 alu=8f", v_o8, c8, z8, alu8);
        end
        issue8(8'h20, 8'h10, 4'b1011);
        repeat (8) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL mul_ovf: got v=%b c=%b z=%b alu=%h, want v=1 c=1 z=1 alu=00", v_o8, c8, z8, alu8);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        r_i8 = 1'b0;
        issue8(8'h12, 8'h34, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({v_o8, c8, z8, alu8, r_o8} !== {1'b1, 1'b0, 1'b0, 8'h46, 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b c=%b z=%b alu=%h rdy=%b, want v=1 c=0 z=0 alu=46 rdy=0",
                         i, v_o8, c8, z8, alu8, r_o8);
            end
        end
        @(negedge clk);
        r_i8 = 1'b1; a8 = 8'hAA; b8 = 8'hFF; op8 = 4'b0110; v_i8 = 1'b1;
        #1;
        n_cmp++;
        if (r_o8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_comb: got %b, want 1", r_o8);
        end
        @(posedge clk);
        #1 v_i8 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b1, 1'b0, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL xor_after_bp: got v=%b c=%b z=%b alu=%h, want v=1 c=0 z=0 alu=55", v_o8, c8, z8, alu8);
        end
    endtask

    task automatic test_shift_rot_cmp();
        logic [7:0] ta[14]  = '{8'h81, 8'h80, 8'h03, 8'h5A, 8'h12, 8'h3C, 8'h01, 8'h5A,
                                8'h81, 8'hF0, 8'hF0, 8'h07, 8'hFF, 8'hC8};
        logic [7:0] tb[14]  = '{8'h09, 8'h07, 8'hC8, 8'h5A, 8'h34, 8'h08, 8'h01, 8'h5B,
                                8'h01, 8'h3C, 8'h0F, 8'h05, 8'h01, 8'h03};
        logic [3:0] top[14] = '{4'h8, 4'h3, 4'hA, 4'h7, 4'hF, 4'h2, 4'h9, 4'h7,
                                4'h2, 4'h4, 4'h5, 4'h1, 4'h0, 4'hA};
        logic [7:0] tr[14]  = '{8'h03, 8'h01, 8'h01, 8'h01, 8'h00, 8'h3C, 8'h80, 8'h00,
                                8'h02, 8'h30, 8'hFF, 8'h02, 8'h00, 8'h00};
        logic       tc[14]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        r_i8 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            issue8(ta[i], tb[i], top[i]);
            @(negedge clk);
            n_cmp++;
            if ({v_o8, c8, z8, alu8} !== {1'b1, tc[i], (tr[i] == 8'h00), tr[i]}) begin
                n_fail++;
                $display("FAIL vec[%0d] op=%h a=%h b=%h: got v=%b c=%b z=%b alu=%h, want c=%b alu=%h",
                         i, top[i], ta[i], tb[i], v_o8, c8, z8, alu8, tc[i], tr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        r_i8 = 1'b1;
        issue8(8'd7, 8'd9, 4'b1011);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b0, 1'b0, 1'b1, 8'h00} || st8 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got v=%b c=%b z=%b alu=%h st=%0d, want v=0 c=0 z=1 alu=00 st=0",
                     v_o8, c8, z8, alu8, st8);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (v_o8 !== 1'b0 || r_o8 !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got valid=%b ready=%b, want 0 1", i, v_o8, r_o8);
            end
        end
        issue8(8'd1, 8'd1, 4'b0000);
        @(negedge clk);
        n_cmp++;
        if ({v_o8, c8, z8, alu8} !== {1'b1, 1'b0, 1'b0, 8'h02}) begin
            n_fail++;
            $display("FAIL add_after_reset: got v=%b c=%b z=%b alu=%h, want v=1 c=0 z=0 alu=02", v_o8, c8, z8, alu8);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        logic [3:0]  op;
        exp_q.delete();
        r_i8 = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({v_o8, c8, z8, alu8} !== {1'b1, e[16], (e[7:0] == 8'h00), e[7:0]}) begin
                    n_fail++;
                    $display("FAIL stream8[%0d]: got v=%b c=%b z=%b alu=%h, want v=1 c=%b alu=%h",
                             i - 1, v_o8, c8, z8, alu8, e[16], e[7:0]);
                end
            end
            if (i < 16) begin
                op = 4'($urandom_range(0, 14));
                if (op >= 4'd11) op = op + 4'd1;
                a8 = 8'($urandom()); b8 = 8'($urandom()); op8 = op; v_i8 = 1'b1;
                exp_q.push_back(model(8, {8'd0, a8}, {8'd0, b8}, op));
            end else begin
                v_i8 = 1'b0;
            end
        end
    endtask

    task automatic test_stream16_mul();
        logic [16:0] e;
        logic        pend;
        int          sent, got, cyc;
        localparam int N = 24;
        exp_q.delete();
        pend = 1'b0; sent = 0; got = 0; cyc = 0;
        while ((sent < N || got < N) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            r_i16 = ($urandom_range(0, 3) != 0);
            if (v_o16 && r_i16) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream16_extra: unexpected result alu=%h", alu16);
                end else begin
                    e = exp_q.pop_front();
                    if ({c16, z16, alu16} !== {e[16], (e[15:0] == 16'h0000), e[15:0]}) begin
                        n_fail++;
                        $display("FAIL stream16[%0d]: got c=%b z=%b alu=%h, want c=%b alu=%h",
                                 got, c16, z16, alu16, e[16], e[15:0]);
                    end
                end
                got++;
            end
            if (!pend && sent < N) begin
                a16 = 16'($urandom()); b16 = 16'($urandom());
                op16 = ($urandom_range(0, 2) == 0) ? 4'b1011 : 4'($urandom_range(0, 15));
                pend = 1'b1;
            end
            v_i16 = pend;
            #1;
            if (pend && r_o16) begin
                exp_q.push_back(model(16, a16, b16, op16));
                sent++;
                pend = 1'b0;
            end
        end
        v_i16 = 1'b0;
        r_i16 = 1'b0;
        n_cmp++;
        if (got != N || sent != N) begin
            n_fail++;
            $display("FAIL stream16_count: got sent=%0d received=%0d in %0d cycles, want %0d each", sent, got, cyc, N);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_shift_rot_cmp();
        test_reset_mid_mul();
        test_back_to_back();
        test_stream16_mul();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
